// File: rtl/exe_mem_stage.sv
// Memory-stage front end: 2-entry queue of execute results, issues loads/stores
// to the data-memory port and emits single-cycle writeback records in FIFO order.
//
// state     | meaning
// IDLE      | evaluate queue head (pass-through writeback or launch request)
// REQ       | memory request held stable until mem_req_ready
// WAIT_RESP | load accepted, waiting for mem_resp_valid
module exe_mem_stage #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         exe_mem,
  input  logic [127:0] result,
  input  logic [63:0]  flags,
  input  logic [3:0]   dest_reg,
  input  logic [1:0]   mem_op,
  input  logic [63:0]  store_data,
  output logic         exe_stall,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_we,
  output logic [63:0]  mem_req_addr,
  output logic [63:0]  mem_req_data,
  input  logic         mem_resp_valid,
  input  logic [63:0]  mem_resp_data,
  output logic         wb_valid,
  output logic [3:0]   wb_reg,
  output logic [63:0]  wb_data,
  output logic [63:0]  wb_hi,
  output logic [63:0]  wb_flags
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQ       = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  logic [127:0] res_mem_q   [DEPTH];
  logic [63:0]  flags_mem_q [DEPTH];
  logic [3:0]   dest_mem_q  [DEPTH];
  logic [1:0]   op_mem_q    [DEPTH];
  logic [63:0]  sd_mem_q    [DEPTH];

  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic [1:0] state_q, state_d;
  logic       push, pop;

  logic        mem_req_valid_q, mem_req_valid_d;
  logic        mem_req_we_q, mem_req_we_d;
  logic [63:0] mem_req_addr_q, mem_req_addr_d;
  logic [63:0] mem_req_data_q, mem_req_data_d;
  logic        wb_valid_q, wb_valid_d;
  logic [3:0]  wb_reg_q, wb_reg_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic [63:0] wb_hi_q, wb_hi_d;
  logic [63:0] wb_flags_q, wb_flags_d;

  logic [127:0] head_res;
  logic [63:0]  head_flags, head_sd;
  logic [3:0]   head_dest;
  logic [1:0]   head_op;

  // Stall comes from the registered count only, so a same-cycle pop never lowers it.
  assign exe_stall = (count_q == 2'd2);
  assign push      = exe_mem && !exe_stall;

  assign head_res   = res_mem_q[rd_ptr_q];
  assign head_flags = flags_mem_q[rd_ptr_q];
  assign head_dest  = dest_mem_q[rd_ptr_q];
  assign head_op    = op_mem_q[rd_ptr_q];
  assign head_sd    = sd_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      res_mem_q[wr_ptr_q]   <= result;
      flags_mem_q[wr_ptr_q] <= flags;
      dest_mem_q[wr_ptr_q]  <= dest_reg;
      op_mem_q[wr_ptr_q]    <= mem_op;
      sd_mem_q[wr_ptr_q]    <= store_data;
    end
  end

  always_comb begin
    state_d         = state_q;
    pop             = 1'b0;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_we_d    = mem_req_we_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_data_d  = mem_req_data_q;
    wb_valid_d      = 1'b0;
    wb_reg_d        = wb_reg_q;
    wb_data_d       = wb_data_q;
    wb_hi_d         = wb_hi_q;
    wb_flags_d      = wb_flags_q;
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          if (head_op == OP_LOAD || head_op == OP_STORE) begin
            mem_req_valid_d = 1'b1;
            mem_req_we_d    = (head_op == OP_STORE);
            mem_req_addr_d  = head_res[63:0];
            mem_req_data_d  = head_sd;
            state_d         = REQ;
          end else begin
            wb_valid_d = 1'b1;
            wb_reg_d   = head_dest;
            wb_data_d  = head_res[63:0];
            wb_hi_d    = head_res[127:64];
            wb_flags_d = head_flags;
            pop        = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          if (mem_req_we_q) begin
            pop     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (mem_resp_valid) begin
          wb_valid_d = 1'b1;
          wb_reg_d   = head_dest;
          wb_data_d  = mem_resp_data;
          wb_hi_d    = 64'd0;
          wb_flags_d = head_flags;
          pop        = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      count_q         <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= 64'd0;
      mem_req_data_q  <= 64'd0;
      wb_valid_q      <= 1'b0;
      wb_reg_q        <= 4'd0;
      wb_data_q       <= 64'd0;
      wb_hi_q         <= 64'd0;
      wb_flags_q      <= 64'd0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_q ^ push;
      rd_ptr_q        <= rd_ptr_q ^ pop;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_data_q  <= mem_req_data_d;
      wb_valid_q      <= wb_valid_d;
      wb_reg_q        <= wb_reg_d;
      wb_data_q       <= wb_data_d;
      wb_hi_q         <= wb_hi_d;
      wb_flags_q      <= wb_flags_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we    = mem_req_we_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_data  = mem_req_data_q;
  assign wb_valid      = wb_valid_q;
  assign wb_reg        = wb_reg_q;
  assign wb_data       = wb_data_q;
  assign wb_hi         = wb_hi_q;
  assign wb_flags      = wb_flags_q;

endmodule
